// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signals of the two-port data RAM arbiter.
// slave = arbiter side, master = requester/RAM side (testbench).
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // port 0 (CPU controller)
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              ack0;
    // port 1 (DMA/loader)
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              ack1;
    // shared read data and status
    logic [DATA_W-1:0] rdata;
    logic              busy;
    // RAM strobes
    logic              ram_ena;
    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_rdata,
        output gnt0, ack0, gnt1, ack1, rdata, busy,
        output ram_ena, ram_read, ram_write, ram_addr, ram_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_rdata,
        input  gnt0, ack0, gnt1, ack1, rdata, busy,
        input  ram_ena, ram_read, ram_write, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single-port data RAM. Port 0 has fixed
// priority; a starve counter forces a port-1 grant after STARVE_MAX
// consecutive port-0 grants made while port 1 was waiting. Every access is
// IDLE (arbitrate) -> SETUP -> HOLD -> ACK, all outputs registered.
module ram_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, HOLD, ACK} state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t            state;
    logic              win;       // owner of the current/last access, 1 = port 1
    logic              we_q;
    logic [3:0]        starve;
    logic              gnt0_q, gnt1_q, ack0_q, ack1_q;
    logic              ena_q, rd_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              pick1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Winner selection and request mux, only meaningful in IDLE
    always_comb begin
        pick1     = bus.req1 && (!bus.req0 || starve == SMAX);
        sel_we    = pick1 ? bus.we1    : bus.we0;
        sel_addr  = pick1 ? bus.addr1  : bus.addr0;
        sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;
    end

    // Access sequencer: arbitration, request latching and strobe generation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            win     <= 1'b1;
            we_q    <= 1'b0;
            starve  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            ena_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // pick1 is forced once starve hits SMAX, so the increment
                    // path never runs past the limit
                    if (!bus.req1 || pick1)
                        starve <= '0;
                    else if (bus.req0)
                        starve <= starve + 4'd1;
                    if (bus.req0 || bus.req1) begin
                        state  <= SETUP;
                        win    <= pick1;
                        we_q   <= sel_we;
                        addr_q <= sel_addr;
                        if (sel_we)
                            wdata_q <= sel_wdata;
                        gnt0_q <= !pick1;
                        gnt1_q <= pick1;
                        ena_q  <= 1'b1;
                        rd_q   <= !sel_we;
                        wr_q   <= sel_we;
                    end
                end
                SETUP: begin
                    state <= HOLD;
                end
                HOLD: begin
                    state  <= ACK;
                    ena_q  <= 1'b0;
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b0;
                    ack0_q <= !win;
                    ack1_q <= win;
                    // RAM data is valid the cycle after SETUP presented the address
                    if (!we_q)
                        rdata_q <= bus.ram_rdata;
                end
                ACK: begin
                    state  <= IDLE;
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state != IDLE);
    assign bus.ram_ena   = ena_q;
    assign bus.ram_read  = rd_q;
    assign bus.ram_write = wr_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
endmodule
